// File: rtl/mod4_pkg.sv
// Shared types for the mod-4 accumulating scheduler: controller states and accumulator width.
package mod4_pkg;

    localparam int ACC_W = 2;

    typedef logic [ACC_W-1:0] acc_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARB   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

endpackage

// File: rtl/mod4_acc_sched_if.sv
// Request/grant bundle between the requesters (master) and the scheduler (slave).
interface mod4_acc_sched_if #(
    parameter int N_REQ = 4
);
    import mod4_pkg::*;

    logic [N_REQ-1:0]   REQ;
    logic [2*N_REQ-1:0] INC;
    logic               HOLD;
    logic               CLR;
    logic [N_REQ-1:0]   GNT;
    acc_t               ACC;
    logic               O;
    logic               WRAP;

    modport master (
        output REQ, INC, HOLD, CLR,
        input  GNT, ACC, O, WRAP
    );

    modport slave (
        input  REQ, INC, HOLD, CLR,
        output GNT, ACC, O, WRAP
    );

endinterface

// File: rtl/mod4_acc_core.sv
// Mod-4 accumulator with registered carry-out pulse and match compare; result visible the cycle after add_en.
// No backpressure: every enabled add is taken; clr wins over add.
module mod4_acc_core
    import mod4_pkg::*;
#(
    parameter acc_t MATCH = 2'b01
) (
    input  logic CLK,
    input  logic RST,
    input  logic add_en,
    input  acc_t wt,
    input  logic clr,
    output acc_t acc,
    output logic carry,
    output logic match
);

    acc_t             acc_q, acc_d;
    logic             carry_q, carry_d;
    logic [ACC_W:0]   sum;

    always_comb begin
        sum     = {1'b0, acc_q} + {1'b0, wt};
        acc_d   = acc_q;
        carry_d = 1'b0;
        if (clr) begin
            acc_d = '0;
        end else if (add_en) begin
            acc_d   = sum[ACC_W-1:0];
            carry_d = sum[ACC_W];
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
        end
    end

    assign acc   = acc_q;
    assign carry = carry_q;
    // Moore output: depends only on the registered accumulator
    assign match = (acc_q == MATCH);

endmodule

// File: rtl/mod4_acc_sched.sv
// Round-robin arbiter feeding the winner's weight into a mod-4 accumulator; grant and ACC update on the same edge.
// HOLD stalls arbitration, CLR zeroes ACC and suppresses the grant; a granted requester is masked for one edge.
module mod4_acc_sched
    import mod4_pkg::*;
#(
    parameter int   N_REQ = 4,
    parameter acc_t MATCH = 2'b01
) (
    input  logic             CLK,
    input  logic             RST,
    mod4_acc_sched_if.slave  bus
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t             st_q, st_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   elig;
    logic               any_elig;
    logic               win_vld;
    logic [PTR_W-1:0]   win_idx;
    logic [PTR_W-1:0]   idx;
    acc_t               win_wt;
    acc_t               acc;
    logic               carry;
    logic               match;

    always_comb begin
        elig     = bus.REQ & ~gnt_q;
        any_elig = |elig;
        win_vld  = 1'b0;
        win_idx  = '0;
        idx      = '0;
        // Search upward from the pointer, wrapping at N_REQ-1
        for (int k = 0; k < N_REQ; k++) begin
            idx = PTR_W'((int'(ptr_q) + k) % N_REQ);
            if (!win_vld && elig[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
        if (bus.HOLD || bus.CLR) begin
            win_vld = 1'b0;
        end
        win_wt = acc_t'(bus.INC >> (2 * int'(win_idx)));

        gnt_d = '0;
        ptr_d = ptr_q;
        if (win_vld) begin
            gnt_d[win_idx] = 1'b1;
            ptr_d          = PTR_W'((int'(win_idx) + 1) % N_REQ);
        end

        st_d = st_q;
        case (st_q)
            ST_IDLE: begin
                if (bus.HOLD)      st_d = ST_PAUSE;
                else if (any_elig) st_d = ST_ARB;
            end
            ST_ARB: begin
                if (bus.HOLD)       st_d = ST_PAUSE;
                else if (!any_elig) st_d = ST_IDLE;
            end
            ST_PAUSE: begin
                if (!bus.HOLD)     st_d = any_elig ? ST_ARB : ST_IDLE;
            end
            default:               st_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            st_q  <= ST_IDLE;
            ptr_q <= '0;
            gnt_q <= '0;
        end else begin
            st_q  <= st_d;
            ptr_q <= ptr_d;
            gnt_q <= gnt_d;
        end
    end

    mod4_acc_core #(
        .MATCH (MATCH)
    ) u_core (
        .CLK    (CLK),
        .RST    (RST),
        .add_en (win_vld),
        .wt     (win_wt),
        .clr    (bus.CLR),
        .acc    (acc),
        .carry  (carry),
        .match  (match)
    );

    assign bus.GNT  = gnt_q;
    assign bus.ACC  = acc;
    assign bus.WRAP = carry;
    assign bus.O    = match;

endmodule

// File: tb/tb_mod4_acc_sched.sv
// Directed-vector bench: the driver queues expected {GNT,ACC,WRAP,O}; a monitor checks each edge.
module tb_mod4_acc_sched;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    always #5 CLK = ~CLK;

    mod4_acc_sched_if #(.N_REQ(4)) bus();

    mod4_acc_sched #(
        .N_REQ (4),
        .MATCH (2'b01)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    typedef struct {
        string      nm;
        logic [7:0] val;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic logic [7:0] snap();
        return {bus.GNT, bus.ACC, bus.WRAP, bus.O};
    endfunction

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got gnt=%b acc=%0d wrap=%b o=%b, expected gnt=%b acc=%0d wrap=%b o=%b",
                     nm, got[7:4], got[3:2], got[1], got[0], exp[7:4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Monitor: outputs settle after each rising edge; compare against the next queued expectation
    always @(posedge CLK) begin
        #2;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk(e.nm, snap(), e.val);
        end
    end

    task automatic drive_push(input logic [3:0] req, input logic [7:0] inc, input logic hold,
                              input logic clr, input logic [3:0] eg, input logic [1:0] ea,
                              input logic ew, input logic eo, input string nm);
        exp_t e;
        bus.REQ  = req;
        bus.INC  = inc;
        bus.HOLD = hold;
        bus.CLR  = clr;
        e.nm  = nm;
        e.val = {eg, ea, ew, eo};
        q.push_back(e);
    endtask

    task automatic vec(input logic [3:0] req, input logic [7:0] inc, input logic hold,
                       input logic clr, input logic [3:0] eg, input logic [1:0] ea,
                       input logic ew, input logic eo, input string nm);
        @(negedge CLK);
        drive_push(req, inc, hold, clr, eg, ea, ew, eo, nm);
    endtask

    initial begin
        bus.REQ  = '0;
        bus.INC  = '0;
        bus.HOLD = 1'b0;
        bus.CLR  = 1'b0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        #1;
        chk("reset_state", snap(), 8'b0000_00_0_0);

        // Single grant, then masking of the just-granted requester
        vec(4'b0001, 8'h01, 0, 0, 4'b0001, 2'd1, 0, 1, "t1_grant");
        vec(4'b0001, 8'h01, 0, 0, 4'b0000, 2'd1, 0, 1, "t1_mask");
        vec(4'b0000, 8'h00, 0, 1, 4'b0000, 2'd0, 0, 0, "t1_clr");

        @(negedge CLK);
        RST = 1'b1;
        #1;
        RST = 1'b0;

        // Round-robin with all weights 2
        vec(4'b1111, 8'hAA, 0, 0, 4'b0001, 2'd2, 0, 0, "rr0");
        vec(4'b1111, 8'hAA, 0, 0, 4'b0010, 2'd0, 1, 0, "rr1");
        vec(4'b1111, 8'hAA, 0, 0, 4'b0100, 2'd2, 0, 0, "rr2");
        vec(4'b1111, 8'hAA, 0, 0, 4'b1000, 2'd0, 1, 0, "rr3");
        vec(4'b1111, 8'hAA, 0, 0, 4'b0001, 2'd2, 0, 0, "rr4");

        // ACC=3 plus weight 3 wraps to 2
        vec(4'b0010, 8'h04, 0, 0, 4'b0010, 2'd3, 0, 0, "acc_to_3");
        vec(4'b0100, 8'h30, 0, 0, 4'b0100, 2'd2, 1, 0, "wrap_add3");
        vec(4'b0000, 8'h00, 0, 0, 4'b0000, 2'd2, 0, 0, "wrap_one_cycle");

        // HOLD stalls grants; release resumes at the pointer (3); zero weight still granted
        vec(4'b1111, 8'h00, 1, 0, 4'b0000, 2'd2, 0, 0, "hold_c1");
        vec(4'b1111, 8'h00, 1, 0, 4'b0000, 2'd2, 0, 0, "hold_c2");
        vec(4'b1111, 8'h00, 1, 0, 4'b0000, 2'd2, 0, 0, "hold_c3");
        vec(4'b1111, 8'h00, 0, 0, 4'b1000, 2'd2, 0, 0, "hold_release");
        vec(4'b1111, 8'h00, 0, 0, 4'b0001, 2'd2, 0, 0, "zero_inc");
        vec(4'b0000, 8'h00, 0, 0, 4'b0000, 2'd2, 0, 0, "idle_a");

        // CLR with a pending request, and CLR over HOLD
        vec(4'b0010, 8'h04, 0, 0, 4'b0010, 2'd3, 0, 0, "pre_clr");
        vec(4'b0100, 8'h30, 0, 1, 4'b0000, 2'd0, 0, 0, "clr_suppress");
        vec(4'b0100, 8'h30, 0, 0, 4'b0100, 2'd3, 0, 0, "post_clr");
        vec(4'b1111, 8'h30, 1, 1, 4'b0000, 2'd0, 0, 0, "clr_over_hold");
        vec(4'b0000, 8'h00, 0, 0, 4'b0000, 2'd0, 0, 0, "idle_b");

        // Grant stream interrupted by an asynchronous reset
        vec(4'b1111, 8'hFF, 0, 0, 4'b1000, 2'd3, 0, 0, "stream0");
        vec(4'b1111, 8'hFF, 0, 0, 4'b0001, 2'd2, 1, 0, "stream1");
        @(negedge CLK);
        RST = 1'b1;
        #1;
        chk("rst_async", snap(), 8'b0000_00_0_0);
        #1;
        RST = 1'b0;
        drive_push(4'b1111, 8'hFF, 0, 0, 4'b0001, 2'd3, 0, 0, "post_rst_lowest");
        vec(4'b0000, 8'h00, 0, 0, 4'b0000, 2'd3, 0, 0, "idle_c");

        @(posedge CLK);
        #3;
        chk("queue_drained", 8'(q.size()), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
